// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared state encoding and counter sizing helper for the
//                digit-serial adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Digit counter width; a single-digit configuration still needs one bit
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : digit_adder
//  Description : Combinational ripple of DIGIT full-adder slices. Also exposes
//                the carry into the top slice for signed-overflow detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_slice
            assign s[i]     = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co       = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : digit_serial_addsub
//  Description : Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits
//                per cycle with a registered inter-digit carry. Valid/ready
//                handshakes on both the operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH ||
            (WIDTH % ((DIGIT > 0) ? DIGIT : 1)) != 0) begin : g_bad_params
            $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic             w_in_ready;
    logic             w_run;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [WIDTH-1:0] w_sum_shift;

    assign w_accept = in_valid & w_in_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a        (r_a[DIGIT-1:0]),
        .b        (r_b[DIGIT-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb)
    );

    // Operands shift right by one digit; result digits enter from the MSB end
    generate
        if (NDIG > 1) begin : g_shift
            assign w_a_shift   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shift   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_sum_shift = {w_s, r_sum[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign w_a_shift   = '0;
            assign w_b_shift   = '0;
            assign w_sum_shift = w_s;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; DONE can reload directly for back-to-back operations
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = RUN;
            RUN:  if (w_last)   w_state_next = DONE;
            DONE: begin
                if (out_ready) w_state_next = in_valid ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded controls; in DONE a new operand set is taken only as the result leaves
    always_comb begin
        w_in_ready = 1'b0;
        w_run      = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            RUN:     w_run      = 1'b1;
            DONE:    w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Datapath: operand load, one digit per RUN cycle, result capture on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b ^ {WIDTH{sub}};
                r_carry <= cin ^ sub;
                r_cnt   <= '0;
            end else if (w_run) begin
                r_a     <= w_a_shift;
                r_b     <= w_b_shift;
                r_carry <= w_co;
                r_sum   <= w_sum_shift;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cout <= w_co;
                    r_ovf  <= w_co ^ w_c_msb;
                end
            end
            r_out_valid <= (w_state_next == DONE);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
